// File: rtl/cas_player.sv
// rtl/cas_player.sv - CAS image playback engine driving the Level II 500-baud cassette-input bit
// Optional motor gating of playback timing: define CAS_PLAYER_MOTOR_GATE_EN.
module cas_player #(
    parameter int CELL_TICKS  = 3548,
    parameter int HALF_TICKS  = 1774,
    parameter int PULSE_TICKS = 200
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic        start,
    input  logic        motor,
    input  logic [15:0] cas_size,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    input  logic        rd_ack,
    output logic        cas_bit,
    output logic        busy,
    output logic        done
);
    localparam int TW = $clog2(CELL_TICKS);
    localparam logic [TW-1:0] T_CLK_END  = TW'(PULSE_TICKS - 1);
    localparam logic [TW-1:0] T_GAP1_END = TW'(HALF_TICKS - 1);
    localparam logic [TW-1:0] T_DATA_END = TW'(HALF_TICKS + PULSE_TICKS - 1);
    localparam logic [TW-1:0] T_CELL_END = TW'(CELL_TICKS - 1);

    typedef enum logic [2:0] {IDLE, PRIME, CLK_PULSE, GAP1, DATA_PULSE, GAP2, DONE} state_t;

    state_t        state;
    logic [TW-1:0] tick;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    pf_reg;
    logic          pf_valid;
    logic          pf_needed;
    logic          stall;
    logic [15:0]   ptr;
    logic [15:0]   len;
    logic          run;
    logic          in_cell;
    logic          tick_en;
    logic          ack_ok;
    logic          cur_level;

`ifdef CAS_PLAYER_MOTOR_GATE_EN
    assign run = motor;
`else
    logic unused_motor;
    assign unused_motor = motor;
    assign run = 1'b1;
`endif

    assign in_cell   = (state == CLK_PULSE) || (state == GAP1) ||
                       (state == DATA_PULSE) || (state == GAP2);
    assign tick_en   = cpu_ce && run && in_cell && !stall;
    assign ack_ok    = rd_ack && rd_req;
    // Level the current state asks for when no threshold is crossed this cycle.
    assign cur_level = ((state == CLK_PULSE) && !stall) || ((state == DATA_PULSE) && shreg[7]);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            tick      <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            pf_reg    <= '0;
            pf_valid  <= 1'b0;
            pf_needed <= 1'b0;
            stall     <= 1'b0;
            ptr       <= '0;
            len       <= '0;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            cas_bit   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (start) begin
            len       <= cas_size;
            ptr       <= '0;
            tick      <= '0;
            pf_valid  <= 1'b0;
            pf_needed <= 1'b0;
            stall     <= 1'b0;
            rd_req    <= 1'b0;
            cas_bit   <= 1'b0;
            if (cas_size == 16'd0) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end else begin
                state <= PRIME;
                busy  <= 1'b1;
                done  <= 1'b0;
            end
        end else begin
            cas_bit <= cur_level && run;

            if (ack_ok) begin
                rd_req <= 1'b0;
                ptr    <= ptr + 16'd1;
                if (state == PRIME) begin
                    shreg     <= rd_data;
                    bit_idx   <= 3'd7;
                    tick      <= '0;
                    state     <= CLK_PULSE;
                    cas_bit   <= run;
                    pf_needed <= 1'b1;
                end else begin
                    pf_reg   <= rd_data;
                    pf_valid <= 1'b1;
                end
            end else if (!rd_req && state == PRIME) begin
                rd_req  <= 1'b1;
                rd_addr <= ptr;
            end else if (!rd_req && pf_needed && in_cell) begin
                pf_needed <= 1'b0;
                if (ptr < len) begin
                    rd_req  <= 1'b1;
                    rd_addr <= ptr;
                end
            end

            // A starved byte boundary parks in CLK_PULSE at tick 0 with the line low.
            if (stall) begin
                if (pf_valid) begin
                    shreg     <= pf_reg;
                    pf_valid  <= 1'b0;
                    stall     <= 1'b0;
                    bit_idx   <= 3'd7;
                    pf_needed <= 1'b1;
                    cas_bit   <= run;
                end
            end else if (tick_en) begin
                tick <= tick + 1'b1;
                case (state)
                    CLK_PULSE: if (tick == T_CLK_END) begin
                        state   <= GAP1;
                        cas_bit <= 1'b0;
                    end
                    GAP1: if (tick == T_GAP1_END) begin
                        state   <= DATA_PULSE;
                        cas_bit <= shreg[7];
                    end
                    DATA_PULSE: if (tick == T_DATA_END) begin
                        state   <= GAP2;
                        cas_bit <= 1'b0;
                    end
                    GAP2: if (tick == T_CELL_END) begin
                        tick <= '0;
                        if (bit_idx != 3'd0) begin
                            bit_idx <= bit_idx - 3'd1;
                            shreg   <= {shreg[6:0], 1'b0};
                            state   <= CLK_PULSE;
                            cas_bit <= 1'b1;
                        end else if (pf_valid) begin
                            shreg     <= pf_reg;
                            pf_valid  <= 1'b0;
                            bit_idx   <= 3'd7;
                            pf_needed <= 1'b1;
                            state     <= CLK_PULSE;
                            cas_bit   <= 1'b1;
                        end else if (ptr == len && !rd_req) begin
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            cas_bit <= 1'b0;
                        end else begin
                            state   <= CLK_PULSE;
                            stall   <= 1'b1;
                            cas_bit <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/cas_player.md
# cas_player

Cassette playback engine for the TRS-80 core. It reads bytes of a loaded CAS image from the cassette region of the download RAM (byte offsets from 0x10000) through a request/acknowledge port. It serialises them MSB-first into the Level II 500-baud pulse stream and drives the cassette-input bit sampled by the CPU on port 0xFF. Timing counts CPU clock enables, so playback follows the selected clockspeed.

## Interface
Parameters:
- CELL_TICKS, 3548: cpu_ce ticks per bit cell (2 ms at 1.774 MHz).
- HALF_TICKS, 1774: tick offset of the data pulse within a cell.
- PULSE_TICKS, 200: pulse width in ticks.

Ports:
- clk_sys  in  1  system clock, 42 MHz.
- reset  in  1  synchronous, active-high.
- cpu_ce  in  1  CPU clock enable; one tick per high cycle.
- start  in  1  one-cycle pulse; rewinds to offset 0 and arms playback.
- motor  in  1  cassette motor relay from the CPU latch.
- cas_size  in  16  image length in bytes; sampled on start.
- rd_req  out  1  byte fetch request.
- rd_addr  out  16  byte offset within the cassette region.
- rd_data  in  8  fetched byte; valid in the rd_ack cycle.
- rd_ack  in  1  one-cycle acknowledge.
- cas_bit  out  1  cassette input level; 1 during a pulse.
- busy  out  1  playback armed and not finished.
- done  out  1  image exhausted; held until start or reset.

## Operation
- States: IDLE, PRIME, CLK_PULSE, GAP1, DATA_PULSE, GAP2, DONE.
- start, from any state:
  - Latch cas_size into len.
  - Set ptr=0 and clear the prefetch-valid flag.
  - Drop any outstanding request.
  - Go to PRIME, or to DONE if len==0.
- PRIME:
  - Fetch byte ptr and load it into the shift register.
  - Increment ptr.
  - Enter CLK_PULSE with bit index 7 and tick count 0.
- Per cell:
  - CLK_PULSE: ticks 0..PULSE_TICKS-1.
  - GAP1: until tick HALF_TICKS.
  - DATA_PULSE: ticks HALF_TICKS..HALF_TICKS+PULSE_TICKS-1. cas_bit is 1 only if the current bit is 1; for a 0 bit, cas_bit stays 0 and the state still advances.
  - GAP2: until tick CELL_TICKS-1. The next cell then starts at tick 0.
- Bits go out MSB first. After bit 0:
  - If ptr_bytes_sent==len, go to DONE.
  - Otherwise load the shift register from the prefetch register and continue.
- Prefetch:
  - On entry to bit 7 of each byte, when ptr<len, issue a fetch of ptr into the prefetch register.
  - Increment ptr on ack.
  - At a byte boundary with prefetch not valid, hold the cell counter at 0 in CLK_PULSE with cas_bit=0 until the ack arrives.
- Handshake:
  - rd_req rises with rd_addr stable.
  - Both hold until the rd_ack cycle, and rd_req drops the cycle after.
  - At most one request is outstanding at a time.
  - rd_ack without a pending request is ignored.
- busy=1 in PRIME through GAP2.
- DONE: cas_bit=0, done=1, rd_req=0.

## Timing
- Reset values: state IDLE, cas_bit=0, rd_req=0, rd_addr=0, busy=0, done=0, ptr=0, prefetch invalid.
- The tick counter advances only on cycles where cpu_ce=1 and the run gate is true (see Configuration).
- cas_bit is registered. It changes one clk_sys cycle after the cpu_ce cycle that crosses a threshold.
- A start and an rd_ack in the same cycle: start wins and the ack is discarded.
- Reset mid-fetch clears rd_req in the next cycle. The subsequent ack is ignored.
- ptr and rd_addr are 16 bits. len==0xFFFF plays offsets 0..0xFFFE and never wraps.
- A start with len==0 reaches DONE in 1 cycle, with no fetch.

## Configuration
- CAS_PLAYER_MOTOR_GATE_EN defined:
  - Run gate = motor.
  - With motor=0, the tick counter and state freeze and cas_bit is forced to 0.
  - Fetch handshakes still complete.
  - Motor on resumes at the frozen tick.
- Not defined:
  - Run gate = 1; motor is ignored.
  - Playback runs from start to DONE continuously.

## Test plan
- Byte 0x80, len=1, motor=1, cpu_ce every cycle:
  - cas_bit=1 on ticks 0-199 and 1774-1973 of cell 0.
  - Cells 1-7 pulse only at 0-199.
  - done=1 after 8×3548 ticks.
- Image {0xA5,0x3C}, ack latency 5 cycles: pulse pattern decodes 10100101 then 00111100. rd_addr sequence is 0,1. No stall is seen between bytes.
- Ack latency 4000 cycles at the byte boundary: cas_bit=0 and the counter holds at 0 until the ack. The next cell then starts with its clock pulse.
- MOTOR_GATE_EN, motor dropped at tick 1000 of a cell for 500 cycles: cas_bit=0 and the tick count is frozen at 1000. The cell resumes intact when motor returns.
- start during byte 2 of 4: rd_req drops, rd_addr=0 is requested next and done stays 0. With len=0 instead, done=1 one cycle after start.
- reset asserted in DATA_PULSE with rd_req=1: the next cycle shows cas_bit=0, rd_req=0, busy=0 and done=0. The late rd_ack is ignored.
